// File: rtl/panda_pkg.sv
// Constants shared by the CDB arbiter, ROB, reservation stations and map table.
package panda_pkg;
  localparam int TAG_W     = 7;
  localparam int CDB_WIDTH = 6;
  localparam logic [TAG_W-1:0] NULL_TAG = 7'h7f;
endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Combinational rotating-priority selector: picks up to CDB_WIDTH requesters
// starting at ptr and packs them densely into CDB slots.
module rr_select
  import panda_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_slot_idx [CDB_WIDTH],
  output logic [CDB_WIDTH-1:0] o_slot_vld,
  output logic [PW-1:0]      o_next_ptr
);

  int w_cnt;
  int w_idx;
  int w_last;

  always_comb begin
    o_grant    = '0;
    o_slot_vld = '0;
    o_next_ptr = i_ptr;
    for (int k = 0; k < CDB_WIDTH; k++) o_slot_idx[k] = '0;
    w_cnt  = 0;
    w_idx  = 0;
    w_last = 0;
    // Walk requesters in rotated order; the scan position doubles as slot order.
    for (int j = 0; j < NUM_REQ; j++) begin
      w_idx = (int'(i_ptr) + j) % NUM_REQ;
      if (i_req[w_idx] && (w_cnt < CDB_WIDTH)) begin
        o_grant[w_idx]        = 1'b1;
        o_slot_vld[w_cnt]     = 1'b1;
        o_slot_idx[w_cnt]     = PW'(w_idx);
        w_last                = w_idx;
        w_cnt                 = w_cnt + 1;
      end
    end
    if (w_cnt > 0) o_next_ptr = PW'((w_last + 1) % NUM_REQ);
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grants of up to CDB_WIDTH completing
// functional units, broadcast one cycle later from registered slots.
module cdb_arbiter
  import panda_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int TAG_W   = panda_pkg::TAG_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       fu_req,
  input  logic [NUM_REQ*TAG_W-1:0] fu_tag,
  output logic [NUM_REQ-1:0]       fu_grant,
  output logic [CDB_WIDTH-1:0]     cdb_pr_ready,
  output logic [TAG_W-1:0]         cdb_pr_tag_0,
  output logic [TAG_W-1:0]         cdb_pr_tag_1,
  output logic [TAG_W-1:0]         cdb_pr_tag_2,
  output logic [TAG_W-1:0]         cdb_pr_tag_3,
  output logic [TAG_W-1:0]         cdb_pr_tag_4,
  output logic [TAG_W-1:0]         cdb_pr_tag_5,
  output logic                     cdb_busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [TAG_W-1:0] L_NULL = {TAG_W{1'b1}};

  logic [PW-1:0]        r_ptr;
  logic [CDB_WIDTH-1:0] r_ready;
  logic [TAG_W-1:0]     r_tag [CDB_WIDTH];
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_grant;
  logic [PW-1:0]        w_slot_idx [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] w_slot_vld;
  logic [PW-1:0]        w_next_ptr;
  logic [TAG_W-1:0]     w_slot_tag [CDB_WIDTH];
  logic                 w_busy;

  rr_select #(.NUM_REQ(NUM_REQ), .PW(PW)) u_sel (
    .i_req      (fu_req),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_slot_idx (w_slot_idx),
    .o_slot_vld (w_slot_vld),
    .o_next_ptr (w_next_ptr)
  );

  // Grants are suppressed during reset so no FU drops a request that is then lost.
  assign fu_grant = reset ? '0 : w_grant;
  assign w_busy   = ($countones(fu_req) > CDB_WIDTH);

  always_comb begin
    for (int k = 0; k < CDB_WIDTH; k++) begin
      w_slot_tag[k] = w_slot_vld[k] ? fu_tag[int'(w_slot_idx[k])*TAG_W +: TAG_W] : L_NULL;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr   <= '0;
      r_ready <= '0;
      r_busy  <= 1'b0;
      for (int k = 0; k < CDB_WIDTH; k++) r_tag[k] <= L_NULL;
    end else begin
      r_ptr   <= w_next_ptr;
      r_ready <= w_slot_vld;
      r_busy  <= w_busy;
      for (int k = 0; k < CDB_WIDTH; k++) r_tag[k] <= w_slot_tag[k];
    end
  end

  assign cdb_pr_ready = r_ready;
  assign cdb_pr_tag_0 = r_tag[0];
  assign cdb_pr_tag_1 = r_tag[1];
  assign cdb_pr_tag_2 = r_tag[2];
  assign cdb_pr_tag_3 = r_tag[3];
  assign cdb_pr_tag_4 = r_tag[4];
  assign cdb_pr_tag_5 = r_tag[5];
  assign cdb_busy     = r_busy;

endmodule
